shiftreg_seq_ctrl: RTL
======================

# shiftreg_seq_ctrl

Transfer sequencer for the serial bidirectional shift register. It accepts a parallel word and a shift direction through a valid/ready request port. It then drives the register's `mode`/`din` inputs for exactly WIDTH shift cycles while sampling the register's serial `dout`. Finally it returns the WIDTH bits shifted out through a valid/ready response port.

## Interface
- `WIDTH`, 4: shift register depth in bits, and the number of shift cycles per transfer; legal range WIDTH >= 2.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  controller can accept a request.
- `req_dir`  in  1  direction; 0 = mode 0, LSB-first; 1 = mode 1, MSB-first.
- `req_data`  in  WIDTH  word to shift in.
- `sr_mode`  out  1  to shift register `mode`.
- `sr_din`  out  1  to shift register `din`.
- `sr_en`  out  1  shift-cycle qualifier, for registers with an enable; high only in SHIFT.
- `sr_dout`  in  1  from shift register `dout`.
- `rsp_valid`  out  1  captured word available.
- `rsp_ready`  in  1  consumer accepts the response.
- `rsp_data`  out  WIDTH  bits captured from `sr_dout` during the transfer.
- `busy`  out  1  high in SHIFT and DONE.

## Operation
- States: IDLE, SHIFT, DONE. The state register, bit counter (`$clog2(WIDTH+1)` bits), data, dir and capture registers are all clocked. Every output is a registered value.
- **Reset** (`rst` low, acts asynchronously):
  - State goes to IDLE.
  - `req_ready`=0, `sr_en`=0, `sr_din`=0, `sr_mode`=0, `rsp_valid`=0, `rsp_data`=0, `busy`=0.
  - Counter and data registers are cleared.
- **IDLE**:
  - `req_ready`=1, `sr_en`=0, `sr_din`=0; `sr_mode` holds the last direction used.
  - On `req_valid & req_ready`: latch `req_data` and `req_dir`, clear the counter, go to SHIFT. `req_ready` drops at the same edge.
- **SHIFT**, per cycle k = 0..WIDTH-1:
  - Outputs: `sr_en`=1, `sr_mode`=dir.
  - `sr_din` = data[k] when dir=0, data[WIDTH-1-k] when dir=1.
  - At the end of cycle k, sample `sr_dout` into cap[k] (dir=0) or cap[WIDTH-1-k] (dir=1), then increment the counter.
  - After the sample at k=WIDTH-1, go to DONE.
- **DONE**:
  - `rsp_valid`=1; `rsp_data`=cap, held stable.
  - `sr_en`=0, `sr_din`=0.
  - On `rsp_valid & rsp_ready`: `rsp_valid`=0, go to IDLE.
- `req_valid` is ignored outside IDLE. `req_data` and `req_dir` may change freely after acceptance.
- `sr_dout` is treated as a synchronous signal in the `clk` domain; it is not synchronised.
- The sampled bit is the value on `sr_dout` during that SHIFT cycle, i.e. before the register's own shift at the same edge. Therefore `rsp_data` holds the register's prior contents in transmit order.

## Timing
- Request accepted at edge E0. SHIFT occupies the cycles between E0 and E(WIDTH). `rsp_valid` rises at E(WIDTH), which is WIDTH cycles after acceptance.
- `sr_en` is high for exactly WIDTH consecutive cycles per transfer, never more or fewer.
- If `rsp_ready` is already high when DONE is entered, DONE lasts 1 cycle. IDLE then lasts at least 1 cycle, so the minimum spacing between acceptances is WIDTH+2 cycles.
- Backpressure: DONE persists indefinitely while `rsp_ready`=0. `rsp_data`, `sr_*` and `req_ready`=0 stay stable.
- After reset release, `req_ready` rises at the first rising edge of `clk`.
- Reset asserted mid-SHIFT or mid-DONE: the transfer is abandoned with no response. All outputs go immediately to their reset values, and no partial `rsp_valid` pulse appears.

## Test plan
- **Reset**: hold `rst`=0 for 3 cycles → all outputs 0. Release → `req_ready`=1 one edge later, `busy`=0.
- **Dir 0 transfer** (WIDTH=4): `req_data`=4'b1011, `req_dir`=0; bench drives `sr_dout`=0,1,1,0 over the SHIFT cycles → `sr_din`=1,1,0,1; `sr_mode`=0; `sr_en` high exactly 4 cycles; `rsp_valid` 4 cycles after acceptance; `rsp_data`=4'b0110.
- **Dir 1 transfer**: `req_data`=4'b1011, `req_dir`=1; `sr_dout`=1,0,0,0 → `sr_din`=1,0,1,1; `sr_mode`=1; `rsp_data`=4'b1000.
- **Response backpressure**: `rsp_ready`=0 for 5 cycles in DONE while `req_valid`=1 → `rsp_valid`/`rsp_data` stable, `req_ready`=0, no new acceptance, `sr_en`=0. Raise `rsp_ready` → one handshake, IDLE on the next cycle.
- **Reset mid-shift**: assert `rst` after the 2nd SHIFT cycle → `sr_en` and `busy` drop without waiting for a clock edge. After release, no `rsp_valid` appears and `req_ready`=1 after one edge.
- **Back-to-back loopback** with a behavioural WIDTH=4 bidirectional shift register model: `req_valid` and `rsp_ready` held high, two requests 4'hA then 4'h5 (dir 0), register pre-loaded 4'h0 → acceptances exactly 6 cycles apart. First `rsp_data`=4'h0, second `rsp_data`=4'hA.

Source files
------------

// File: rtl/shiftreg_seq_ctrl_if.sv
// Request/response channels of the shift-register transfer sequencer.
//   req_valid/req_ready : request handshake
//   req_dir             : 0 = mode 0 (LSB first), 1 = mode 1 (MSB first)
//   req_data            : word to shift into the register
//   rsp_valid/rsp_ready : response handshake
//   rsp_data            : word shifted out of the register
// master = requester/consumer side, slave = sequencer side.
interface shiftreg_seq_ctrl_if #(
  parameter int unsigned WIDTH = 4
);
  logic             req_valid;
  logic             req_ready;
  logic             req_dir;
  logic [WIDTH-1:0] req_data;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_data;

  modport master (
    output req_valid, req_dir, req_data, rsp_ready,
    input  req_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, req_dir, req_data, rsp_ready,
    output req_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/shiftreg_seq_ctrl.sv
// Transfer sequencer for a serial bidirectional shift register.
// Accepts a word and direction, drives the register's mode/din for exactly
// WIDTH shift cycles while sampling its dout, then returns the captured bits.
//   clk     : rising-edge clock
//   rst     : asynchronous active-low reset
//   bus     : request/response channels (slave modport)
//   sr_mode : register mode (holds last direction used)
//   sr_din  : serial data into the register
//   sr_en   : shift qualifier, high only while shifting
//   sr_dout : serial data out of the register (clk domain)
//   busy    : high while shifting or holding a response
// All outputs come straight from flops.
module shiftreg_seq_ctrl #(
  parameter int unsigned WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  shiftreg_seq_ctrl_if.slave   bus,
  output logic                 sr_mode,
  output logic                 sr_din,
  output logic                 sr_en,
  input  logic                 sr_dout,
  output logic                 busy
);

  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam int unsigned IW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t           state, state_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic [WIDTH-1:0] data, data_n;
  logic             dir, dir_n;
  logic [WIDTH-1:0] cap, cap_n;
  logic             req_ready, req_ready_n;
  logic             rsp_valid, rsp_valid_n;
  logic [WIDTH-1:0] rsp_data, rsp_data_n;
  logic             sr_mode_n, sr_din_n, sr_en_n, busy_n;

  // Bit position of shift cycle k in transmit order.
  function automatic logic [IW-1:0] pos_of(input logic [CW-1:0] k, input logic d);
    return IW'(d ? (WIDTH - 1 - 32'(k)) : 32'(k));
  endfunction

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    data_n      = data;
    dir_n       = dir;
    cap_n       = cap;
    req_ready_n = req_ready;
    rsp_valid_n = rsp_valid;
    rsp_data_n  = rsp_data;
    sr_mode_n   = sr_mode;
    sr_din_n    = sr_din;
    sr_en_n     = sr_en;
    busy_n      = busy;

    unique case (state)
      IDLE: begin
        req_ready_n = 1'b1;
        sr_en_n     = 1'b0;
        sr_din_n    = 1'b0;
        if (bus.req_valid && req_ready) begin
          state_n     = SHIFT;
          cnt_n       = '0;
          data_n      = bus.req_data;
          dir_n       = bus.req_dir;
          req_ready_n = 1'b0;
          busy_n      = 1'b1;
          // Outputs for shift cycle 0 are prepared at the accepting edge so
          // they are already registered during that cycle.
          sr_en_n     = 1'b1;
          sr_mode_n   = bus.req_dir;
          sr_din_n    = bus.req_data[pos_of('0, bus.req_dir)];
        end
      end

      SHIFT: begin
        // dout is sampled before the register's own shift at this edge.
        cap_n[pos_of(cnt, dir)] = sr_dout;
        cnt_n = cnt + CW'(1);
        if (cnt == LAST) begin
          state_n     = DONE;
          sr_en_n     = 1'b0;
          sr_din_n    = 1'b0;
          rsp_valid_n = 1'b1;
          rsp_data_n  = cap_n;
        end else begin
          sr_din_n = data[pos_of(cnt_n, dir)];
        end
      end

      DONE: begin
        if (rsp_valid && bus.rsp_ready) begin
          state_n     = IDLE;
          rsp_valid_n = 1'b0;
          req_ready_n = 1'b1;
          busy_n      = 1'b0;
        end
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      data      <= '0;
      dir       <= 1'b0;
      cap       <= '0;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      sr_mode   <= 1'b0;
      sr_din    <= 1'b0;
      sr_en     <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      data      <= data_n;
      dir       <= dir_n;
      cap       <= cap_n;
      req_ready <= req_ready_n;
      rsp_valid <= rsp_valid_n;
      rsp_data  <= rsp_data_n;
      sr_mode   <= sr_mode_n;
      sr_din    <= sr_din_n;
      sr_en     <= sr_en_n;
      busy      <= busy_n;
    end
  end

  assign bus.req_ready = req_ready;
  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_data  = rsp_data;

endmodule
